irq_arbiter: RTL and testbench

- Interrupt controller between peripheral interrupt sources (UART, SPI, I2C, TIMER0, TIMER2, GPIO) and the core's IRQ_REQ/IRQ_ADD inputs.
- Latches source events as pending flags, applies a software mask and the global I flag (SREG[7]), and picks the winner by fixed priority.
- Drives a single request/vector pair to the core and sequences each service with an acknowledge/RETI handshake.
- Runs on the CPU clock (hclk domain).

---
 rtl/irq_arbiter.sv | 176 +++++++++++++++++
 tb/tb_irq_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: fixed-priority interrupt controller sitting between the
// peripheral interrupt lines and the core's IRQ_REQ/IRQ_ADD inputs.
// Source events are latched as pending flags, gated by a software mask
// and the global I flag, and the lowest eligible index wins. Each service
// is sequenced with an irq_ack / reti handshake.
//
// Optional build macro: IRQ_NEST_EN
//   Defined   -> two-level nesting: a higher-priority source may preempt a
//                running service; served indices are kept on a depth-2 stack.
//   Undefined -> strictly non-nested operation.
module irq_arbiter #(
  parameter int              NSRC = 8,
  parameter logic [NSRC-1:0] EDGE = {NSRC{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            gie,
  input  logic            msk_we,
  input  logic [NSRC-1:0] msk_din,
  input  logic            irq_ack,
  input  logic            reti,
  output logic            IRQ_REQ,
  output logic [3:0]      IRQ_ADD,
  output logic [NSRC-1:0] msk,
  output logic [NSRC-1:0] pend
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [NSRC-1:0] L_ONE = NSRC'(1);

  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_msk;
  logic [1:0]      r_state;
  logic [3:0]      r_win;
  logic            r_req;
  logic [3:0]      r_add;

  logic [NSRC-1:0] w_elig;
  logic            w_any;
  logic [3:0]      w_win;
  logic            w_ack;
  logic            w_win_on;
  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [1:0]      w_ret_state;

`ifdef IRQ_NEST_EN
  logic [3:0] r_stk0;
  logic [3:0] r_stk1;
  logic [1:0] r_depth;
  logic [3:0] w_top;

  assign w_top       = (r_depth == 2'd2) ? r_stk1 : r_stk0;
  assign w_ret_state = (r_depth != 2'd0) ? S_SERVICE : S_IDLE;
`else
  assign w_ret_state = S_IDLE;
`endif

  assign w_elig   = r_pend & r_msk;
  assign w_any    = |w_elig;
  assign w_ack    = (r_state == S_REQ) && irq_ack;
  assign w_win_on = |(r_msk & (L_ONE << r_win));
  assign w_set    = src & ~r_src_d;
  assign w_clr    = w_ack ? (L_ONE << r_win) : '0;

  assign IRQ_REQ = r_req;
  assign IRQ_ADD = r_add;
  assign msk     = r_msk;
  assign pend    = r_pend;

  // Lowest set eligible index wins; scanning downwards leaves the lowest one.
  always_comb begin
    w_win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 4'(i);
    end
  end

  // Next pending value: edge bits set-dominant over ack clear, level bits track src.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE[i]) w_pend_nxt[i] = w_set[i] | (r_pend[i] & ~w_clr[i]);
      else         w_pend_nxt[i] = src[i];
    end
  end

  // Source delay line for edge detect plus the pending flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src_d <= '0;
      r_pend  <= '0;
    end else begin
      r_src_d <= src;
      r_pend  <= w_pend_nxt;
    end
  end

  // Software mask register; new value is seen by arbitration one clk later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msk <= '0;
    end else if (msk_we) begin
      r_msk <= msk_din;
    end
  end

  // Request/service sequencer driving the registered request and vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_req   <= 1'b0;
      r_add   <= '0;
`ifdef IRQ_NEST_EN
      r_stk0  <= '0;
      r_stk1  <= '0;
      r_depth <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (gie && w_any) begin
            r_win   <= w_win;
            r_req   <= 1'b1;
            r_add   <= w_win + 4'd1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            r_req   <= 1'b0;
            r_add   <= '0;
            r_state <= S_SERVICE;
`ifdef IRQ_NEST_EN
            if (r_depth == 2'd0) r_stk0 <= r_win;
            else                 r_stk1 <= r_win;
            r_depth <= r_depth + 2'd1;
`endif
          end else if (!gie || !w_win_on) begin
            r_req   <= 1'b0;
            r_add   <= '0;
            r_state <= w_ret_state;
          end
        end
        S_SERVICE: begin
`ifdef IRQ_NEST_EN
          if (reti) begin
            r_depth <= r_depth - 2'd1;
            if (r_depth == 2'd1) r_state <= S_IDLE;
          end else if (gie && w_any && (r_depth != 2'd2) && (w_win < w_top)) begin
            r_win   <= w_win;
            r_req   <= 1'b1;
            r_add   <= w_win + 4'd1;
            r_state <= S_REQ;
          end
`else
          if (reti) r_state <= S_IDLE;
`endif
        end
        default: begin
          r_req   <= 1'b0;
          r_add   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (NSRC=8, all edge sources).
// Expected values are hand-derived; timing reference: inputs change 1 ns
// after a rising edge, outputs are sampled 1 ns after the following edge.
module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic       gie;
  logic       msk_we;
  logic [7:0] msk_din;
  logic       irq_ack;
  logic       reti;
  logic       IRQ_REQ;
  logic [3:0] IRQ_ADD;
  logic [7:0] msk;
  logic [7:0] pend;

  int vectors;
  int miscompares;

  irq_arbiter #(.NSRC(8), .EDGE(8'hFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (src),
    .gie     (gie),
    .msk_we  (msk_we),
    .msk_din (msk_din),
    .irq_ack (irq_ack),
    .reti    (reti),
    .IRQ_REQ (IRQ_REQ),
    .IRQ_ADD (IRQ_ADD),
    .msk     (msk),
    .pend    (pend)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clk worth of inputs, then drop all one-clk pulses.
  task automatic applyStimulus(input logic [7:0] s, input logic we,
                               input logic [7:0] din, input logic ack,
                               input logic rt);
    src     = s;
    msk_we  = we;
    msk_din = din;
    irq_ack = ack;
    reti    = rt;
    @(posedge clk);
    #1;
    src     = '0;
    msk_we  = 1'b0;
    msk_din = '0;
    irq_ack = 1'b0;
    reti    = 1'b0;
  endtask

  // Let n clks pass with no pulses.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    src = '0; gie = 1'b0; msk_we = 1'b0; msk_din = '0;
    irq_ack = 1'b0; reti = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_req",  16'(IRQ_REQ), 16'h0);
    checkOutput("rst_add",  16'(IRQ_ADD), 16'h0);
    checkOutput("rst_msk",  16'(msk),     16'h0);
    checkOutput("rst_pend", 16'(pend),    16'h0);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Priority: src[5] and src[2] together, index 2 wins.
    gie = 1'b1;
    applyStimulus(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("msk_ff", 16'(msk), 16'hFF);
    applyStimulus(8'h24, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("prio_pend", 16'(pend), 16'h24);
    checkOutput("prio_req0", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("prio_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("prio_add", 16'(IRQ_ADD), 16'h3);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ack_req",  16'(IRQ_REQ), 16'h0);
    checkOutput("ack_add",  16'(IRQ_ADD), 16'h0);
    checkOutput("ack_pend", 16'(pend),    16'h20);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reti_req", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("second_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("second_add", 16'(IRQ_ADD), 16'h6);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("second_pend", 16'(pend), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    checkOutput("prio_idle", 16'(IRQ_REQ), 16'h0);

    // Mask gating and mask-clear abort.
    applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mask_pend", 16'(pend), 16'h10);
    idle(1);
    checkOutput("mask_noreq", 16'(IRQ_REQ), 16'h0);
    applyStimulus(8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
    checkOutput("mask_wr_noreq", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("mask_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("mask_add", 16'(IRQ_ADD), 16'h5);
    applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("mclr_req_hold", 16'(IRQ_REQ), 16'h1);
    idle(1);
    checkOutput("mclr_req",  16'(IRQ_REQ), 16'h0);
    checkOutput("mclr_add",  16'(IRQ_ADD), 16'h0);
    checkOutput("mclr_pend", 16'(pend),    16'h10);
    applyStimulus(8'h00, 1'b1, 8'h10, 1'b0, 1'b0);
    idle(1);
    checkOutput("mask_reissue", 16'(IRQ_ADD), 16'h5);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    checkOutput("mask_done_pend", 16'(pend), 16'h0);

    // gie drop before ack, then frozen winner.
    applyStimulus(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    checkOutput("gie_add", 16'(IRQ_ADD), 16'h2);
    gie = 1'b0;
    idle(1);
    checkOutput("gie_drop_req",  16'(IRQ_REQ), 16'h0);
    checkOutput("gie_drop_pend", 16'(pend),    16'h02);
    idle(1);
    checkOutput("gie_off_req", 16'(IRQ_REQ), 16'h0);
    gie = 1'b1;
    idle(1);
    checkOutput("gie_re_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("gie_re_add", 16'(IRQ_ADD), 16'h2);
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("frz_pend", 16'(pend), 16'h03);
    idle(1);
    checkOutput("frz_add", 16'(IRQ_ADD), 16'h2);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("frz_ack_pend", 16'(pend), 16'h01);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    checkOutput("idx0_add", 16'(IRQ_ADD), 16'h1);

    // Set/clear collision on index 0; ack in SERVICE is ignored.
    applyStimulus(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("coll_pend", 16'(pend),    16'h01);
    checkOutput("coll_req",  16'(IRQ_REQ), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("svc_ack_ign", 16'(pend), 16'h01);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("coll_reti_req", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("coll_req2", 16'(IRQ_REQ), 16'h1);
    checkOutput("coll_add2", 16'(IRQ_ADD), 16'h1);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("coll_clr", 16'(pend), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // Serve index 3, then index 1 arrives during its service.
    applyStimulus(8'h08, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    checkOutput("nest_add3", 16'(IRQ_ADD), 16'h4);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
`ifdef IRQ_NEST_EN
    checkOutput("nest_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("nest_add", 16'(IRQ_ADD), 16'h2);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("nest_ack_pend", 16'(pend), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("nest_pop1_req", 16'(IRQ_REQ), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    checkOutput("nest_idle_req", 16'(IRQ_REQ), 16'h0);
`else
    checkOutput("nonest_req", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("nonest_req2", 16'(IRQ_REQ), 16'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("nonest_reti_req", 16'(IRQ_REQ), 16'h0);
    idle(1);
    checkOutput("nonest_late_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("nonest_late_add", 16'(IRQ_ADD), 16'h2);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    checkOutput("nonest_pend", 16'(pend), 16'h0);
`endif

    // Asynchronous reset while a request is outstanding.
    applyStimulus(8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    checkOutput("pre_rst_req", 16'(IRQ_REQ), 16'h1);
    checkOutput("pre_rst_add", 16'(IRQ_ADD), 16'h7);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_req",  16'(IRQ_REQ), 16'h0);
    checkOutput("arst_add",  16'(IRQ_ADD), 16'h0);
    checkOutput("arst_pend", 16'(pend),    16'h0);
    checkOutput("arst_msk",  16'(msk),     16'h0);
    idle(1);
    rst = 1'b1;
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
